// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential word reads
// to a 1-cycle-latency synchronous IMEM, buffers returned {pc, instr} pairs in
// a DEPTH-entry FIFO and hands them to decode with a valid/ready handshake.
// A redirect flushes the FIFO and the in-flight read and restarts at the target.
module instr_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_en,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  // Architectural state
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pend_pc_q,  pend_pc_d;
  logic             pend_q,     pend_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;

  // FIFO storage (contents are only observable while count != 0)
  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           issue;
  logic           push;
  logic           pop;
  logic           not_empty;

  // Handshake and issue decisions; the credit check counts the in-flight read
  // and ignores a same-cycle pop so the FIFO can never overflow.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
    not_empty = (count_q != '0);
    issue     = rst & ~redirect & (occupancy < DEPTH_L);
    push      = pend_q & ~redirect;
    out_valid = not_empty & ~redirect;
    pop       = out_valid & out_ready;
    imem_en   = issue;
    imem_addr = fetch_pc_q[ADDR_W+1:2];
    count     = count_q;
    out_pc    = not_empty ? pc_mem_q[rd_ptr_q]    : '0;
    out_instr = not_empty ? instr_mem_q[rd_ptr_q] : '0;
  end

  // Next-state computation; redirect overrides every other update.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pend_d     = issue;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      pend_d     = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pend_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage write on a returning read; needs no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= pend_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Testbench for instr_prefetch_queue: directed vector table, hand-written
// reset/wrap sequences and randomized traffic against a queue-based model.
module tb_instr_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  instr_prefetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .ADDR_W   (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous IMEM model, one cycle read latency
  logic [31:0] mem [0:1023];
  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Directed vector table
  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [9:0]  addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rd, input logic [31:0] rpc, input logic rdy,
                     input logic en, input logic [9:0] addr, input logic v,
                     input logic [31:0] pc, input logic [31:0] instr, input logic [2:0] cnt);
    vec_t e;
    e.rd = rd; e.rpc = rpc; e.rdy = rdy; e.en = en; e.addr = addr;
    e.v = v; e.pc = pc; e.instr = instr; e.cnt = cnt;
    tbl.push_back(e);
  endtask

  // Reference model: ordered queue of buffered entries plus one in-flight read
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic        mpend;
  logic [31:0] mpend_pc;
  logic [31:0] mfetch;

  task automatic model_reset();
    mq.delete();
    mpend    = 1'b0;
    mpend_pc = '0;
    mfetch   = 32'h0;
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    int   occ;
    logic e_valid;
    logic e_issue;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    @(negedge clk);
    redirect = rd; redirect_pc = rpc; out_ready = rdy;
    #1;
    occ     = mq.size() + int'(mpend);
    e_valid = (mq.size() != 0) && !rd;
    e_issue = !rd && (occ < 4);
    e_pc    = (mq.size() != 0) ? mq[0].pc    : 32'h0;
    e_instr = (mq.size() != 0) ? mq[0].instr : 32'h0;
    chk("m_count", {29'h0, count}, 32'(mq.size()));
    chk("m_valid", {31'h0, out_valid}, {31'h0, e_valid});
    chk("m_en",    {31'h0, imem_en}, {31'h0, e_issue});
    chk("m_addr",  {22'h0, imem_addr}, {22'h0, mfetch[11:2]});
    chk("m_pc",    out_pc, e_pc);
    chk("m_instr", out_instr, e_instr);
    if (rd) begin
      mq.delete();
      mpend  = 1'b0;
      mfetch = rpc & ~32'h3;
    end else begin
      if (e_valid && rdy) void'(mq.pop_front());
      if (mpend) mq.push_back({mpend_pc, mem[mpend_pc[11:2]]});
      if (e_issue) begin
        mpend_pc = mfetch;
        mfetch   = mfetch + 32'd4;
      end
      mpend = e_issue;
    end
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);

    // rd rpc rdy | en addr v pc instr cnt
    add(0, 0, 1, 1,  0, 0, 32'h00,  0, 0);
    add(0, 0, 1, 1,  1, 0, 32'h00,  0, 0);
    add(0, 0, 1, 1,  2, 1, 32'h00,  0, 1);
    add(0, 0, 1, 1,  3, 1, 32'h04,  1, 1);
    add(0, 0, 0, 1,  4, 1, 32'h08,  2, 1);
    add(0, 0, 0, 1,  5, 1, 32'h08,  2, 2);
    add(0, 0, 0, 0,  6, 1, 32'h08,  2, 3);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 6, 1, 32'h08, 2, 4);
    add(0, 0, 1, 0,  6, 1, 32'h08,  2, 4);
    add(0, 0, 1, 1,  6, 1, 32'h0C,  3, 3);
    add(0, 0, 1, 1,  7, 1, 32'h10,  4, 2);
    add(0, 0, 0, 1,  8, 1, 32'h14,  5, 2);
    add(1, 32'h40, 1, 0, 9, 0, 32'h14, 5, 3);
    add(0, 0, 1, 1, 16, 0, 32'h00,  0, 0);
    add(0, 0, 1, 1, 17, 0, 32'h00,  0, 0);
    add(0, 0, 1, 1, 18, 1, 32'h40, 16, 1);
    add(1, 32'h43, 1, 0, 19, 0, 32'h44, 17, 1);
    add(0, 0, 1, 1, 16, 0, 32'h00,  0, 0);
    add(0, 0, 1, 1, 17, 0, 32'h00,  0, 0);
    add(0, 0, 1, 1, 18, 1, 32'h40, 16, 1);
    add(1, 32'h80, 1, 0, 19, 0, 32'h44, 17, 1);
    add(1, 32'h100, 1, 0, 32, 0, 32'h00, 0, 0);
    add(0, 0, 1, 1, 64, 0, 32'h00,  0, 0);
    add(0, 0, 1, 1, 65, 0, 32'h00,  0, 0);
    add(0, 0, 1, 1, 66, 1, 32'h100, 64, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_en",    {31'h0, imem_en},   32'h0);
    chk("rst_count", {29'h0, count},     32'h0);
    #1 rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      redirect = tbl[i].rd; redirect_pc = tbl[i].rpc; out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_en", i),    {31'h0, imem_en},   {31'h0, tbl[i].en});
      chk($sformatf("tbl%0d_addr", i),  {22'h0, imem_addr}, {22'h0, tbl[i].addr});
      chk($sformatf("tbl%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].v});
      chk($sformatf("tbl%0d_pc", i),    out_pc,             tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), out_instr,          tbl[i].instr);
      chk($sformatf("tbl%0d_count", i), {29'h0, count},     {29'h0, tbl[i].cnt});
    end

    // Asynchronous reset mid-stream with two entries buffered
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      redirect = 1'b0; out_ready = 1'b0;
      #1;
      if (count == 3'd2) found = 1'b1;
    end
    chk("wait_count2", {31'h0, found}, 32'h1);
    rst = 1'b0;
    #1;
    chk("arst_count", {29'h0, count},     32'h0);
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_en",    {31'h0, imem_en},   32'h0);
    chk("arst_pc",    out_pc,             32'h0);
    chk("arst_instr", out_instr,          32'h0);
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_count", {29'h0, count}, 32'h0);
    #1 rst = 1'b1;
    model_reset();

    // Restart at RESET_PC with 3-cycle latency to first valid
    step(0, 0, 1);
    chk("restart_addr", {22'h0, imem_addr}, 32'h0);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("restart_valid", {31'h0, out_valid}, 32'h1);
    chk("restart_pc",    out_pc,             32'h0);

    // Fetch PC wrap and push+pop at count = DEPTH-1
    step(1, 32'hFFFF_FFF4, 0);
    repeat (4) step(0, 0, 0);
    step(0, 0, 1);
    chk("pp_count_a", {29'h0, count}, 32'd3);
    step(0, 0, 1);
    chk("pp_count_b", {29'h0, count}, 32'd3);
    chk("pp_pc_b",    out_pc,         32'hFFFF_FFF8);
    step(0, 0, 1);
    chk("wrap_pc_fc", out_pc,         32'hFFFF_FFFC);
    step(0, 0, 1);
    chk("wrap_pc_0",  out_pc,         32'h0);
    chk("wrap_instr", out_instr,      mem[0]);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      int          bias;
      bias = 1 + ((c / 250) % 4);
      rd   = ($urandom_range(0, 11) == 0);
      rpc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                         : ($urandom & 32'h0000_0FFF);
      rdy  = ($urandom_range(0, 4) < bias);
      step(rd, rpc, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
